io_uart: RTL and testbench

IO_UART -- requirements
Module: io_uart

---
 rtl/io_uart_pkg.sv | 21 ++
 rtl/io_uart_if.sv | 25 ++
 rtl/io_uart_fifo.sv | 60 ++++++
 rtl/io_uart.sv | 237 +++++++++++++++++++++++
 tb/tb_io_uart.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/io_uart_pkg.sv
// Shared constants and types for the IO-mapped UART: register offsets, STATUS bit
// positions and the FSM state encoding used by both the transmitter and receiver.
package io_uart_pkg;

    localparam logic [31:0] RegStatusOffset = 32'h0;
    localparam logic [31:0] RegRxDataOffset = 32'h4;
    localparam logic [31:0] RegTxDataOffset = 32'h8;

    localparam int unsigned StatusRxAvailBit  = 0;
    localparam int unsigned StatusTxReadyBit  = 1;
    localparam int unsigned StatusOverrunBit  = 2;
    localparam int unsigned StatusFrameErrBit = 3;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_state_e;

endpackage

// File: rtl/io_uart_if.sv
// Core IO bus as seen by a memory-mapped peripheral: single-cycle load/store strobes
// with a registered read-data return.
interface io_uart_if;
    logic        io_write_en;
    logic        io_read_en;
    logic [31:0] io_address;
    logic [31:0] io_write_data;
    logic [31:0] io_read_data;

    modport master (
        output io_write_en,
        output io_read_en,
        output io_address,
        output io_write_data,
        input  io_read_data
    );

    modport slave (
        input  io_write_en,
        input  io_read_en,
        input  io_address,
        input  io_write_data,
        output io_read_data
    );
endinterface

// File: rtl/io_uart_fifo.sv
// Synchronous first-word-fall-through FIFO; simultaneous push and pop are legal
// when full (pop frees the slot) and when empty (pop ignored, push accepted).
module io_uart_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic [Width-1:0] mem_q [Depth];
    logic             do_push, do_pop;

    assign full_o     = (count_q == (PtrW + 1)'(Depth));
    assign empty_o    = (count_q == '0);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem_q[rd_ptr_q];

    // Depth is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: register decode, sticky error flags, TX/RX bit FSMs with
// 16-bit baud counters, and a FIFO per direction.
module io_uart
    import io_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h18,
    parameter int unsigned BAUD_DIVIDE  = 434,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic     clk,
    input  logic     reset_n,
    io_uart_if.slave bus,
    output logic     uart_tx,
    input  logic     uart_rx
);
    localparam logic [15:0] BaudLast = 16'(BAUD_DIVIDE - 1);
    localparam logic [15:0] HalfLast = 16'(BAUD_DIVIDE / 2 - 1);

    logic sel_status, sel_rx, sel_tx;
    logic rd_status, rd_rx, wr_tx;
    logic unused_wdata;

    assign sel_status   = (bus.io_address == BASE_ADDRESS + RegStatusOffset);
    assign sel_rx       = (bus.io_address == BASE_ADDRESS + RegRxDataOffset);
    assign sel_tx       = (bus.io_address == BASE_ADDRESS + RegTxDataOffset);
    assign rd_status    = bus.io_read_en && sel_status;
    assign rd_rx        = bus.io_read_en && sel_rx;
    assign wr_tx        = bus.io_write_en && sel_tx;
    assign unused_wdata = ^bus.io_write_data[31:8];

    logic       tx_pop, tx_full, tx_empty;
    logic [7:0] tx_fifo_data;
    logic       rx_push, rx_full, rx_empty;
    logic [7:0] rx_fifo_data;

    uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic        tx_line_q, tx_line_d;
    logic [1:0]  sync_q, sync_d;
    logic        rx_prev_q, rx_s;
    logic        overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic        overrun_ev, frame_err_ev;
    logic [31:0] read_data_q, read_data_d;

    io_uart_fifo #(.Width(8), .Depth(FIFO_DEPTH)) u_tx_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (wr_tx),
        .push_data_i(bus.io_write_data[7:0]),
        .pop_i      (tx_pop),
        .pop_data_o (tx_fifo_data),
        .full_o     (tx_full),
        .empty_o    (tx_empty)
    );

    io_uart_fifo #(.Width(8), .Depth(FIFO_DEPTH)) u_rx_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (rx_push),
        .push_data_i(rx_shift_q),
        .pop_i      (rd_rx),
        .pop_data_o (rx_fifo_data),
        .full_o     (rx_full),
        .empty_o    (rx_empty)
    );

    assign sync_d          = {sync_q[0], uart_rx};
    assign rx_s            = sync_q[1];
    assign uart_tx         = tx_line_q;
    assign bus.io_read_data = read_data_q;

    // Transmitter: STOP chains straight into START when more data is queued.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            StIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_fifo_data;
                    tx_cnt_d   = '0;
                    tx_state_d = StStart;
                end
            end
            StStart: begin
                if (tx_cnt_q == BaudLast) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = StData;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            StData: begin
                if (tx_cnt_q == BaudLast) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    if (tx_bit_q == 3'd7) tx_state_d = StStop;
                    else                  tx_bit_d   = tx_bit_q + 3'd1;
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (tx_cnt_q == BaudLast) begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_fifo_data;
                        tx_state_d = StStart;
                    end else begin
                        tx_state_d = StIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 16'd1;
                end
            end
            default: tx_state_d = StIdle;
        endcase
        case (tx_state_d)
            StStart: tx_line_d = 1'b0;
            StData:  tx_line_d = tx_shift_d[0];
            default: tx_line_d = 1'b1;
        endcase
    end

    // Receiver: a falling edge is only seen after the line has been high, so a
    // frame error with the line held low cannot re-arm until it returns high.
    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_push      = 1'b0;
        overrun_ev   = 1'b0;
        frame_err_ev = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                if (rx_prev_q && !rx_s) begin
                    rx_cnt_d   = '0;
                    rx_state_d = StStart;
                end
            end
            StStart: begin
                if (rx_cnt_q == HalfLast) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_state_d = rx_s ? StIdle : StData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            StData: begin
                if (rx_cnt_q == BaudLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) rx_state_d = StStop;
                    else                  rx_bit_d   = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            StStop: begin
                if (rx_cnt_q == BaudLast) begin
                    rx_cnt_d   = '0;
                    rx_state_d = StIdle;
                    if (rx_s) begin
                        rx_push    = 1'b1;
                        overrun_ev = rx_full && !rd_rx;
                    end else begin
                        frame_err_ev = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end

    always_comb begin
        overrun_d   = overrun_ev || (overrun_q && !rd_status);
        frame_err_d = frame_err_ev || (frame_err_q && !rd_status);
        read_data_d = read_data_q;
        if (bus.io_read_en) begin
            read_data_d = '0;
            if (sel_status) begin
                read_data_d[StatusRxAvailBit]  = !rx_empty;
                read_data_d[StatusTxReadyBit]  = !tx_full;
                read_data_d[StatusOverrunBit]  = overrun_q;
                read_data_d[StatusFrameErrBit] = frame_err_q;
            end else if (sel_rx && !rx_empty) begin
                read_data_d[7:0] = rx_fifo_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_q  <= StIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_line_q   <= 1'b1;
            rx_state_q  <= StIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            sync_q      <= 2'b11;
            rx_prev_q   <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            read_data_q <= '0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_line_q   <= tx_line_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            sync_q      <= sync_d;
            rx_prev_q   <= rx_s;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            read_data_q <= read_data_d;
        end
    end

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart: TX bytes and RX bytes are scoreboarded through
// queues, STATUS reads are compared against constants built from the shared package.
module tb_io_uart;
    import io_uart_pkg::*;

    localparam int unsigned Bd   = 8;
    localparam logic [31:0] Base = 32'h18;
    localparam logic [31:0] AddrStatus = Base + RegStatusOffset;
    localparam logic [31:0] AddrRxData = Base + RegRxDataOffset;
    localparam logic [31:0] AddrTxData = Base + RegTxDataOffset;
    localparam logic [31:0] StRxAvail  = 32'd1 << StatusRxAvailBit;
    localparam logic [31:0] StTxReady  = 32'd1 << StatusTxReadyBit;
    localparam logic [31:0] StOverrun  = 32'd1 << StatusOverrunBit;
    localparam logic [31:0] StFrameErr = 32'd1 << StatusFrameErrBit;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic uart_tx;
    logic uart_rx = 1'b1;

    io_uart_if bus ();

    io_uart #(
        .BASE_ADDRESS(Base),
        .BAUD_DIVIDE (Bd),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus),
        .uart_tx(uart_tx),
        .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [7:0]  tx_exp[$];
    logic [7:0]  rx_exp[$];
    logic        mon_en   = 1'b1;
    logic        mon_busy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
        end
    endtask

    // Bus tasks start and end on a falling edge, so back-to-back calls issue
    // accesses on consecutive cycles.
    task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
        bus.io_write_en   = 1'b1;
        bus.io_address    = addr;
        bus.io_write_data = data;
        @(negedge clk);
        bus.io_write_en = 1'b0;
    endtask

    task automatic io_read(input logic [31:0] addr, output logic [31:0] data);
        bus.io_read_en = 1'b1;
        bus.io_address = addr;
        @(negedge clk);
        bus.io_read_en = 1'b0;
        data = bus.io_read_data;
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        io_read(AddrStatus, d);
        check(tag, d, exp);
    endtask

    task automatic read_rx(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        exp = (rx_exp.size() != 0) ? 32'(rx_exp.pop_front()) : 32'd0;
        io_read(AddrRxData, d);
        check(tag, d, exp);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop);
        uart_rx = 1'b0;
        repeat (Bd) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (Bd) @(negedge clk);
        end
        uart_rx = stop;
        repeat (Bd) @(negedge clk);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_tx_drain(input int budget);
        int cyc = 0;
        while ((tx_exp.size() != 0 || mon_busy) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check("tx_drain", 32'(tx_exp.size()), 32'd0);
    endtask

    task automatic count_tx_lows(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
    endtask

    // Samples each bit near its centre; a wrong bit period drifts off by the stop bit.
    initial begin : tx_monitor
        logic [7:0] bits;
        logic       start_bit;
        logic       stop_bit;
        forever begin
            @(negedge clk);
            if (mon_en && reset_n && uart_tx === 1'b0) begin
                mon_busy = 1'b1;
                repeat (Bd / 2 - 1) @(negedge clk);
                start_bit = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (Bd) @(negedge clk);
                    bits[i] = uart_tx;
                end
                repeat (Bd) @(negedge clk);
                stop_bit = uart_tx;
                check("tx_start_bit", 32'(start_bit), 32'd0);
                check("tx_stop_bit", 32'(stop_bit), 32'd1);
                check("tx_frame_expected", 32'(tx_exp.size() != 0), 32'd1);
                if (tx_exp.size() != 0) check("tx_byte", 32'(bits), 32'(tx_exp.pop_front()));
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : main
        logic [31:0] d;
        int          lows;

        bus.io_write_en   = 1'b0;
        bus.io_read_en    = 1'b0;
        bus.io_address    = '0;
        bus.io_write_data = '0;
        repeat (3) @(negedge clk);
        check("reset_uart_tx", 32'(uart_tx), 32'd1);
        check("reset_read_data", bus.io_read_data, 32'd0);
        reset_n = 1'b1;
        check_status("status_after_reset", StTxReady);
        read_rx("rxdata_empty");

        // Unmapped and read-only registers ignore writes; unmapped reads give 0.
        io_write(AddrStatus, 32'hFF);
        io_write(Base + 32'h40, 32'h12);
        io_read(Base + 32'h40, d);
        check("unmapped_read", d, 32'd0);
        count_tx_lows(20, lows);
        check("no_tx_from_bad_writes", 32'(lows), 32'd0);

        // Single byte transmit.
        tx_exp.push_back(8'h55);
        io_write(AddrTxData, 32'h55);
        wait_tx_drain(400);
        check_status("status_after_tx55", StTxReady);

        // Single byte receive.
        send_byte(8'hA3, 1'b1);
        rx_exp.push_back(8'hA3);
        check_status("status_rx_avail", StRxAvail | StTxReady);
        read_rx("rxdata_a3");
        check_status("status_after_pop", StTxReady);

        // Burst of six TX writes: first leaves at once, sixth finds the FIFO full.
        for (int i = 1; i <= 5; i++) tx_exp.push_back(8'(i));
        for (int i = 1; i <= 6; i++) io_write(AddrTxData, 32'(i));
        wait_tx_drain(1000);
        count_tx_lows(3 * 10 * Bd, lows);
        check("tx_byte6_dropped", 32'(lows), 32'd0);
        check_status("status_after_burst", StTxReady);

        // RX overrun: fifth byte is discarded.
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hC0 + 8'(i), 1'b1);
            if (i < 4) rx_exp.push_back(8'hC0 + 8'(i));
        end
        check_status("status_overrun_set", StRxAvail | StTxReady | StOverrun);
        check_status("status_overrun_clr", StRxAvail | StTxReady);
        for (int i = 0; i < 4; i++) read_rx("rxdata_overrun_seq");
        check_status("status_rx_drained", StTxReady);

        // Framing error, then a short glitch that must be ignored.
        send_byte(8'h3C, 1'b0);
        check_status("status_frame_err", StTxReady | StFrameErr);
        check_status("status_frame_err_clr", StTxReady);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (12 * Bd) @(negedge clk);
        check_status("status_after_glitch", StTxReady);

        // Reset during data bit 3 of 'h50 (bit 3 is 0, so the line must jump high).
        mon_en = 1'b0;
        io_write(AddrTxData, 32'h50);
        repeat (36) @(negedge clk);
        check("tx_bit3_before_reset", 32'(uart_tx), 32'd0);
        reset_n = 1'b0;
        #1;
        check("tx_high_on_reset", 32'(uart_tx), 32'd1);
        check("read_data_on_reset", bus.io_read_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check_status("status_after_mid_reset", StTxReady);
        count_tx_lows(12 * Bd, lows);
        check("no_frame_after_reset", 32'(lows), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "simulation time limit");
    end

endmodule
